// File: rtl/aux_perf_pkg.sv
// Shared definitions for the performance counter bank: FSM encoding and the
// channel numbering used by the 7-segment display mux.
package aux_perf_pkg;

  typedef enum logic {
    PERF_RUN    = 1'b0,
    PERF_FROZEN = 1'b1
  } perf_state_e;

  localparam int unsigned PERF_CH_CYC  = 0;
  localparam int unsigned PERF_CH_JMP  = 1;
  localparam int unsigned PERF_CH_BCH  = 2;
  localparam int unsigned PERF_CH_BED  = 3;
  localparam int unsigned PERF_CH_BUB  = 4;
  localparam int unsigned PERF_CH_LU   = 5;
  localparam int unsigned PERF_NUM_EVT = 6;

endpackage

// File: rtl/aux_perf_channel.sv
// One event channel: live counter, snapshot shadow and sticky overflow flag.
module aux_perf_channel
  import aux_perf_pkg::*;
#(
  parameter int CntBit   = 32,
  parameter bit Saturate = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cnt_en,
  input  logic              i_clr,
  input  logic              i_snap,
  output logic [CntBit-1:0] o_cnt,
  output logic [CntBit-1:0] o_shadow,
  output logic              o_ovf
);

  logic [CntBit-1:0] r_cnt;
  logic [CntBit-1:0] r_shadow;
  logic              r_ovf;
  logic [CntBit:0]   w_sum;

  // Saturate holds the old value on carry-out; wrap keeps the truncated sum.
  function automatic logic [CntBit-1:0] f_limit(input logic [CntBit-1:0] cur,
                                                input logic [CntBit:0]   sum);
    if (sum[CntBit] && Saturate) return cur;
    return sum[CntBit-1:0];
  endfunction

  assign w_sum = {1'b0, r_cnt} + (CntBit+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (i_snap) r_shadow <= r_cnt;
      if (i_clr) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (i_cnt_en) begin
        r_cnt <= f_limit(r_cnt, w_sum);
        if (w_sum[CntBit]) r_ovf <= 1'b1;
      end
    end
  end

  assign o_cnt    = r_cnt;
  assign o_shadow = r_shadow;
  assign o_ovf    = r_ovf;

endmodule

// File: rtl/aux_perf_counter_bank.sv
// Performance counter bank: freeze/run FSM, per-event channels, atomic
// snapshot and a registered indexed readout for the display mux.
module aux_perf_counter_bank
  import aux_perf_pkg::*;
#(
  parameter int NumCh    = 8,
  parameter int CntBit   = 32,
  parameter int IdxBit   = 3,
  parameter bit Saturate = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NumCh-1:0]  inc,
  input  logic              clr,
  input  logic              snap,
  input  logic              freeze,
  input  logic              thaw,
  input  logic [IdxBit-1:0] sel,
  input  logic              rd_shadow,
  output logic [CntBit-1:0] data_out,
  output logic [NumCh-1:0]  ovf,
  output logic              snap_valid,
  output logic              frozen
);

  perf_state_e       r_state;
  perf_state_e       w_state_nxt;
  logic              w_run;
  logic [CntBit-1:0] w_cnt    [NumCh];
  logic [CntBit-1:0] w_shadow [NumCh];
  logic [CntBit-1:0] w_rd;
  logic [CntBit-1:0] r_data_out;
  logic              r_snap_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= PERF_RUN;
    else     r_state <= w_state_nxt;
  end

  // freeze and thaw together toggle, since each is only looked at in its own state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PERF_RUN:    if (freeze) w_state_nxt = PERF_FROZEN;
      PERF_FROZEN: if (thaw)   w_state_nxt = PERF_RUN;
    endcase
  end

  assign w_run  = (r_state == PERF_RUN) && en;
  assign frozen = (r_state == PERF_FROZEN);

  for (genvar gi = 0; gi < NumCh; gi++) begin : g_ch
    aux_perf_channel #(
      .CntBit   (CntBit),
      .Saturate (Saturate)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_cnt_en (w_run && inc[gi]),
      .i_clr    (clr),
      .i_snap   (snap),
      .o_cnt    (w_cnt[gi]),
      .o_shadow (w_shadow[gi]),
      .o_ovf    (ovf[gi])
    );
  end

  // Indices at or above NumCh match no channel and fall through to zero.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (sel == IdxBit'(i)) w_rd = rd_shadow ? w_shadow[i] : w_cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out   <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      r_data_out <= w_rd;
      if (snap) r_snap_valid <= 1'b1;
    end
  end

  assign data_out   = r_data_out;
  assign snap_valid = r_snap_valid;

endmodule

// File: tb/tb_aux_perf_counter_bank.sv
// Bench for aux_perf_counter_bank: three configurations share one stimulus
// table; expectations are queued when a vector is driven and checked after the edge.
module tb_aux_perf_counter_bank;
  import aux_perf_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, clr, snap, freeze, thaw, rd_shadow;
  logic [7:0] inc;
  logic [2:0] sel;

  logic [31:0] d_data;
  logic [7:0]  d_ovf;
  logic        d_sv, d_frz;
  logic [3:0]  w_data;
  logic [5:0]  w_ovf;
  logic        w_sv, w_frz;
  logic [3:0]  s_data;
  logic [5:0]  s_ovf;
  logic        s_sv, s_frz;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aux_perf_counter_bank #(.NumCh(8), .CntBit(32), .IdxBit(3), .Saturate(1'b0)) u_dut_d (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .clr(clr), .snap(snap),
    .freeze(freeze), .thaw(thaw), .sel(sel), .rd_shadow(rd_shadow),
    .data_out(d_data), .ovf(d_ovf), .snap_valid(d_sv), .frozen(d_frz));

  aux_perf_counter_bank #(.NumCh(6), .CntBit(4), .IdxBit(3), .Saturate(1'b0)) u_dut_w (
    .clk(clk), .rst(rst), .en(en), .inc(inc[5:0]), .clr(clr), .snap(snap),
    .freeze(freeze), .thaw(thaw), .sel(sel), .rd_shadow(rd_shadow),
    .data_out(w_data), .ovf(w_ovf), .snap_valid(w_sv), .frozen(w_frz));

  aux_perf_counter_bank #(.NumCh(6), .CntBit(4), .IdxBit(3), .Saturate(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .en(en), .inc(inc[5:0]), .clr(clr), .snap(snap),
    .freeze(freeze), .thaw(thaw), .sel(sel), .rd_shadow(rd_shadow),
    .data_out(s_data), .ovf(s_ovf), .snap_valid(s_sv), .frozen(s_frz));

  typedef struct {
    string       name;
    int          rep;
    logic        rst, en, clr, snap, fz, th, rd;
    logic [7:0]  inc;
    logic [2:0]  sel;
    logic [31:0] dd;
    logic [3:0]  dw, ds;
    logic [7:0]  ovd;
    logic [5:0]  ovw, ovs;
    logic        frz, sv;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(string nm, int rep, int rs, int e, int in, int c, int sn,
                              int fz, int th, int sl, int rd, int dd, int dw, int ds,
                              int ovd, int ovw, int ovs, int fr, int sv);
    vec_t v;
    v.name = nm;   v.rep = rep;
    v.rst  = rs[0]; v.en = e[0]; v.clr = c[0]; v.snap = sn[0];
    v.fz   = fz[0]; v.th = th[0]; v.rd = rd[0];
    v.inc  = 8'(in); v.sel = 3'(sl);
    v.dd   = 32'(dd); v.dw = 4'(dw); v.ds = 4'(ds);
    v.ovd  = 8'(ovd); v.ovw = 6'(ovw); v.ovs = 6'(ovs);
    v.frz  = fr[0]; v.sv = sv[0];
    return v;
  endfunction

  task automatic check(string nm, string what, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, what, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, e;
    rst = 1'b1; en = 1'b0; inc = 8'h00; clr = 1'b0; snap = 1'b0;
    freeze = 1'b0; thaw = 1'b0; sel = 3'd0; rd_shadow = 1'b0;

    //                 name            rep rs en  inc  clr sn fz th sel rd  dd  dw ds  ovd ovw  ovs fr sv
    vecs.push_back(mk("reset",          2, 1, 0, 'h00, 0, 0, 0, 0, 0, 0,  0,  0, 0,  0,  0,   0,  0, 0));
    vecs.push_back(mk("inc0_first",     1, 0, 1, 'h01, 0, 0, 0, 0, 0, 0,  0,  0, 0,  0,  0,   0,  0, 0));
    vecs.push_back(mk("inc0_run",       3, 0, 1, 'h01, 0, 0, 0, 0, 0, 0,  3,  3, 3,  0,  0,   0,  0, 0));
    vecs.push_back(mk("inc0_last",      1, 0, 1, 'h01, 0, 0, 0, 0, 0, 0,  4,  4, 4,  0,  0,   0,  0, 0));
    vecs.push_back(mk("rd_ch0",         1, 0, 1, 'h00, 0, 0, 0, 0, 0, 0,  5,  5, 5,  0,  0,   0,  0, 0));
    vecs.push_back(mk("rd_ch1",         1, 0, 1, 'h00, 0, 0, 0, 0, 1, 0,  0,  0, 0,  0,  0,   0,  0, 0));
    vecs.push_back(mk("en_off",         1, 0, 0, 'h01, 0, 0, 0, 0, 0, 0,  5,  5, 5,  0,  0,   0,  0, 0));
    vecs.push_back(mk("en_off_hold",    1, 0, 1, 'h00, 0, 0, 0, 0, 0, 0,  5,  5, 5,  0,  0,   0,  0, 0));
    vecs.push_back(mk("ch1_fill",       7, 0, 1, 'h02, 0, 0, 0, 0, 1, 0,  6,  6, 6,  0,  0,   0,  0, 0));
    vecs.push_back(mk("snap_clr",       1, 0, 1, 'h02, 1, 1, 0, 0, 1, 0,  7,  7, 7,  0,  0,   0,  0, 1));
    vecs.push_back(mk("shadow_rd",      1, 0, 1, 'h00, 0, 0, 0, 0, 1, 1,  7,  7, 7,  0,  0,   0,  0, 1));
    vecs.push_back(mk("live_rd",        1, 0, 1, 'h00, 0, 0, 0, 0, 1, 0,  0,  0, 0,  0,  0,   0,  0, 1));
    vecs.push_back(mk("shadow_ch0",     1, 0, 1, 'h00, 0, 0, 0, 0, 0, 1,  5,  5, 5,  0,  0,   0,  0, 1));
    vecs.push_back(mk("ch2_fill",      15, 0, 1, 'h04, 0, 0, 0, 0, 2, 0, 14, 14,14,  0,  0,   0,  0, 1));
    vecs.push_back(mk("ch2_ovf",        1, 0, 1, 'h04, 0, 0, 0, 0, 2, 0, 15, 15,15,  0,  4,   4,  0, 1));
    vecs.push_back(mk("ch2_post",       3, 0, 1, 'h04, 0, 0, 0, 0, 2, 0, 18,  2,15,  0,  4,   4,  0, 1));
    vecs.push_back(mk("ch2_read",       1, 0, 1, 'h00, 0, 0, 0, 0, 2, 0, 19,  3,15,  0,  4,   4,  0, 1));
    vecs.push_back(mk("clr_ovf",        1, 0, 1, 'h04, 1, 0, 0, 0, 2, 0, 19,  3,15,  0,  0,   0,  0, 1));
    vecs.push_back(mk("clr_read",       1, 0, 1, 'h00, 0, 0, 0, 0, 2, 0,  0,  0, 0,  0,  0,   0,  0, 1));
    vecs.push_back(mk("freeze_edge",    1, 0, 1, 'hFF, 0, 0, 1, 0, 3, 0,  0,  0, 0,  0,  0,   0,  1, 1));
    vecs.push_back(mk("frozen_hold",   10, 0, 1, 'hFF, 0, 0, 0, 0, 3, 0,  1,  1, 1,  0,  0,   0,  1, 1));
    vecs.push_back(mk("thaw_edge",      1, 0, 1, 'hFF, 0, 0, 0, 1, 3, 0,  1,  1, 1,  0,  0,   0,  0, 1));
    vecs.push_back(mk("thaw_count",     1, 0, 1, 'hFF, 0, 0, 0, 0, 3, 0,  1,  1, 1,  0,  0,   0,  0, 1));
    vecs.push_back(mk("thaw_read",      1, 0, 1, 'h00, 0, 0, 0, 0, 3, 0,  2,  2, 2,  0,  0,   0,  0, 1));
    vecs.push_back(mk("toggle_a",       1, 0, 1, 'h00, 0, 0, 1, 1, 3, 0,  2,  2, 2,  0,  0,   0,  1, 1));
    vecs.push_back(mk("toggle_b",       1, 0, 1, 'h00, 0, 0, 1, 1, 3, 0,  2,  2, 2,  0,  0,   0,  0, 1));
    vecs.push_back(mk("thaw_in_run",    1, 0, 1, 'hFF, 0, 0, 0, 1, 3, 0,  2,  2, 2,  0,  0,   0,  0, 1));
    vecs.push_back(mk("freeze_again",   1, 0, 1, 'hFF, 0, 0, 1, 0, 7, 0,  3,  0, 0,  0,  0,   0,  1, 1));
    vecs.push_back(mk("frozen_sel7",    1, 0, 1, 'hFF, 0, 0, 0, 0, 7, 0,  4,  0, 0,  0,  0,   0,  1, 1));
    vecs.push_back(mk("rst_mid",        1, 1, 1, 'hFF, 0, 1, 0, 1, 7, 0,  0,  0, 0,  0,  0,   0,  0, 0));
    vecs.push_back(mk("rst_sel7",       1, 0, 1, 'h00, 0, 0, 0, 0, 7, 0,  0,  0, 0,  0,  0,   0,  0, 0));
    vecs.push_back(mk("rst_shadow",     1, 0, 1, 'h00, 0, 0, 0, 0, 1, 1,  0,  0, 0,  0,  0,   0,  0, 0));
    vecs.push_back(mk("post_rst_cnt",   1, 0, 1, 'h01, 0, 0, 0, 0, PERF_CH_CYC, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("post_rst_read",  1, 0, 1, 'h00, 0, 0, 0, 0, PERF_CH_CYC, 0, 1, 1, 1, 0, 0, 0, 0, 0));

    for (int vi = 0; vi < vecs.size(); vi++) begin
      v = vecs[vi];
      for (int r = 0; r < v.rep; r++) begin
        rst = v.rst; en = v.en; inc = v.inc; clr = v.clr; snap = v.snap;
        freeze = v.fz; thaw = v.th; sel = v.sel; rd_shadow = v.rd;
        if (r == v.rep - 1) exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check(e.name, "data_d", d_data,       e.dd);
          check(e.name, "data_w", 32'(w_data),  32'(e.dw));
          check(e.name, "data_s", 32'(s_data),  32'(e.ds));
          check(e.name, "ovf_d",  32'(d_ovf),   32'(e.ovd));
          check(e.name, "ovf_w",  32'(w_ovf),   32'(e.ovw));
          check(e.name, "ovf_s",  32'(s_ovf),   32'(e.ovs));
          check(e.name, "frz_d",  32'(d_frz),   32'(e.frz));
          check(e.name, "frz_w",  32'(w_frz),   32'(e.frz));
          check(e.name, "frz_s",  32'(s_frz),   32'(e.frz));
          check(e.name, "sv_d",   32'(d_sv),    32'(e.sv));
          check(e.name, "sv_w",   32'(w_sv),    32'(e.sv));
          check(e.name, "sv_s",   32'(s_sv),    32'(e.sv));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
